counter_param: RTL

Parametrised up/down counter that generalises the fixed 32-bit enable counter: configurable width, programmable prescaler, programmable terminal value (modulo), parallel load, wrap or saturate mode, and sticky overflow/underflow flags. It is the general-purpose timing and event-count primitive for the simulation designs. Its outputs drive timeout logic and periodic-tick consumers.

---
 rtl/counter_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/counter_param.sv
// -----------------------------------------------------------------------------
// counter_param
//   Parametrised up/down counter with programmable prescaler, programmable
//   terminal value (0..limit), parallel load with clamp, wrap or saturate
//   behaviour at the boundaries, and sticky overflow/underflow flags.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   PRESCALE_W prescaler width in bits (>= 1)
//   SATURATE   0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports
//   clk        rising-edge clock
//   n_reset    asynchronous active-low reset
//   en         count enable; the prescaler advances only while high
//   dir        1 = count up, 0 = count down
//   load       synchronous parallel load (wins over counting)
//   load_val   value to load, clamped to limit
//   limit      terminal value; counting range is 0..limit
//   prescale   one counter step every prescale+1 enabled cycles
//   clr_flags  clears ovf and udf (a same-edge set wins)
//   cnt_out    current count, registered
//   tc         one-cycle terminal-count pulse, registered
//   ovf        sticky: an up step was taken at the up boundary
//   udf        sticky: a down step was taken at the down boundary
// -----------------------------------------------------------------------------
module counter_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_flags,
  output logic [WIDTH-1:0]      cnt_out,
  output logic                  tc,
  output logic                  ovf,
  output logic                  udf
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  step;
  logic                  at_top;
  logic                  at_bottom;
  logic [WIDTH-1:0]      load_clamped;
  logic [WIDTH-1:0]      cnt_next;
  logic                  tc_next;
  logic                  ovf_set;
  logic                  udf_set;

  // '>=' rather than '==' so that lowering prescale at run time never lets
  // pre_cnt run past the new terminal value.
  assign step         = en && !load && (pre_cnt >= prescale);

  // '>=' treats a count left above a freshly lowered limit as the boundary.
  assign at_top       = (cnt_out >= limit);
  assign at_bottom    = (cnt_out == '0);
  assign load_clamped = (load_val > limit) ? limit : load_val;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves one unassigned and no latch is inferred.
    cnt_next = cnt_out;
    tc_next  = 1'b0;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;

    if (load) begin
      cnt_next = load_clamped;
    end else if (step) begin
      if (dir) begin
        if (at_top) begin
          cnt_next = SATURATE ? limit : '0;
          tc_next  = 1'b1;
          ovf_set  = 1'b1;
        end else begin
          cnt_next = cnt_out + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
          cnt_next = SATURATE ? '0 : limit;
          tc_next  = 1'b1;
          udf_set  = 1'b1;
        end else begin
          // Plain decrement even when cnt_out sits above a lowered limit.
          cnt_next = cnt_out - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_out <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      cnt_out <= cnt_next;
      tc      <= tc_next;

      if (load || step) begin
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= pre_cnt + PRESCALE_W'(1);
      end

      // A set on the same edge as clr_flags wins.
      ovf <= ovf_set | (ovf & ~clr_flags);
      udf <= udf_set | (udf & ~clr_flags);
    end
  end

endmodule
